dmem_ll_responder: RTL and testbench
====================================

// Module: dmem_ll_responder
// PURPOSE
//   Data-memory responder for the MEM-stage memory port. Accepts word requests (ce/we/addr/wdata),
//   adds a fixed programmable wait latency, returns read data with a one-cycle ready pulse.
//   Owns the LL/SC reservation (link bit + linked word address): LL sets it, SC tests and clears it,
//   plain stores to the linked word and pipeline flushes break it. SC returns its success flag as rdata.
// PARAMETERS
//   ADDR_W       10  word-address bits; array depth = 2**ADDR_W words of 32 bits
//   WAIT_CYCLES  2   extra wait states; request-to-ready latency = WAIT_CYCLES+1 cycles (0 legal)
// PORTS
//   clk      in   1   rising-edge clock
//   rst      in   1   reset, synchronous, active-high
//   ce       in   1   request strobe; sampled only in IDLE
//   we       in   1   1 = store, 0 = load (captured with ce)
//   ll       in   1   load-linked qualifier (valid with ce & !we)
//   sc       in   1   store-conditional qualifier (valid with ce & we)
//   addr     in   32  byte address; word index = addr[ADDR_W+1:2]; upper bits ignored (alias)
//   wdata    in   32  store data
//   flush    in   1   exception/eret; clears reservation
//   rdata    out  32  load data, or {31'b0,sc_ok} for SC; held until next completion
//   ready    out  1   one-cycle completion pulse
//   err      out  1   pulses with ready when request was illegal (misaligned or ll&sc)
//   llbit    out  1   reservation valid (registered)
// BEHAVIOUR
//   Reset: state=IDLE, wait counter=0, ready=0, err=0, rdata=0, llbit=0, linked addr=0; array not cleared.
//   FSM: IDLE -(ce)-> WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES==0); WAIT counts WAIT_CYCLES then -> RESP;
//     RESP -> IDLE unconditionally. ready=1 exactly in RESP. Next request accepted in the cycle after RESP.
//   Capture: in IDLE with ce=1, register we/ll/sc/addr/wdata; input changes afterwards are ignored.
//   Commit: on the edge entering RESP: store writes array, load registers rdata, reservation updated.
//   Illegal: addr[1:0]!=0 or (ll&sc) -> no array write, rdata=0, err=1 in RESP, reservation unchanged.
//   ll/sc qualifiers with the wrong we polarity are ignored (plain access).
//   LL: plain read plus llbit<=1, linked addr<=word index.
//   SC: sc_ok = llbit & (linked addr == word index); write only if sc_ok; rdata={31'b0,sc_ok}; llbit<=0.
//   Plain store to word index == linked addr while llbit=1 -> llbit<=0; store to other word keeps it.
//   flush=1 on any edge -> llbit<=0; flush wins over an LL committing on the same edge; flush does not
//     abort an in-flight request (SC completing with flush fails: sc_ok uses llbit before clear, but
//     flush on the commit edge forces sc_ok=0 and no write).
//   rst mid-request: request dropped, no write, no ready pulse.
//   ce asserted while WAIT/RESP is ignored (not queued).
// TESTING
//   WAIT_CYCLES=2: store 0xDEADBEEF @0x10, load @0x10 -> ready 3 cycles after ce, rdata=0xDEADBEEF.
//   LL @0x20 then SC 0x1234 @0x20 -> llbit 1 then 0, SC rdata=1, later load @0x20 = 0x1234.
//   LL @0x20, SW @0x20, SC @0x20 -> SC rdata=0, memory holds SW value; LL, SW @0x24, SC @0x20 -> rdata=1.
//   LL @0x20, flush pulse, SC @0x20 -> rdata=0, no write; flush on LL commit edge -> llbit stays 0.
//   Store @0x13 -> err=1 with ready, memory @0x10 unchanged; ce with ll=sc=1 -> err=1.
//   rst asserted during WAIT of a store -> no ready, target word unchanged, llbit=0; WAIT_CYCLES=0 -> 1-cycle latency.

Source files
------------

// File: rtl/dmem_ll_responder.sv
// Data-memory responder with a fixed wait latency and the LL/SC reservation.
// A request is captured in IDLE and committed on the edge that enters RESP.
module dmem_ll_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic        ll,
  input  logic        sc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        llbit
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, ll_q, sc_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem_q [0:(2**ADDR_W)-1];
  logic               llbit_q, llbit_d;
  logic [ADDR_W-1:0]  link_q, link_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, err_q, err_d;

  logic               r_we_s, r_ll_s, r_sc_s;
  logic [ADDR_W+1:0]  r_addr_s;
  logic [31:0]        r_wdata_s;
  logic [ADDR_W-1:0]  idx_s;
  logic               commit_s, illegal_s, sc_ok_s, mem_we_s;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // Request view: live inputs while IDLE (zero-wait commit), captured copy afterwards
  always_comb begin
    if (state_q == S_IDLE) begin
      r_we_s    = we;
      r_ll_s    = ll;
      r_sc_s    = sc;
      r_addr_s  = addr[ADDR_W+1:0];
      r_wdata_s = wdata;
    end else begin
      r_we_s    = we_q;
      r_ll_s    = ll_q;
      r_sc_s    = sc_q;
      r_addr_s  = addr_q;
      r_wdata_s = wdata_q;
    end
  end

  // Sequencing: IDLE -> WAIT -> RESP -> IDLE, commit strobed on entry to RESP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce) begin
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d  = S_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commit: array write enable, read data, error flag and reservation update
  always_comb begin
    illegal_s = (r_addr_s[1:0] != 2'b00) | (r_ll_s & r_sc_s);
    idx_s     = r_addr_s[ADDR_W+1:2];
    sc_ok_s   = llbit_q & (link_q == idx_s) & ~flush;
    mem_we_s  = 1'b0;
    llbit_d   = llbit_q;
    link_d    = link_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    if (commit_s) begin
      if (illegal_s) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else if (r_we_s && r_sc_s) begin
        mem_we_s = sc_ok_s;
        rdata_d  = {31'd0, sc_ok_s};
        llbit_d  = 1'b0;
      end else if (r_we_s) begin
        mem_we_s = 1'b1;
        if (link_q == idx_s) begin
          llbit_d = 1'b0;
        end else begin
          llbit_d = llbit_q;
        end
      end else begin
        rdata_d = mem_q[idx_s];
        if (r_ll_s) begin
          llbit_d = 1'b1;
          link_d  = idx_s;
        end else begin
          llbit_d = llbit_q;
        end
      end
    end else begin
      err_d = 1'b0;
    end
    // A flush on the same edge beats any reservation set by a committing LL
    llbit_d = llbit_d & ~flush;
  end

  // Control, capture and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      llbit_q <= 1'b0;
      link_q  <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_IDLE) && ce) begin
        we_q    <= we;
        ll_q    <= ll;
        sc_q    <= sc;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
      end
      llbit_q <= llbit_d;
      link_q  <= link_d;
      rdata_q <= rdata_d;
      ready_q <= commit_s;
      err_q   <= err_d;
    end
  end

  // Storage array, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[idx_s] <= r_wdata_s;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign llbit = llbit_q;

endmodule

// File: tb/tb_dmem_ll_responder.sv
// Scoreboard bench: a 2-wait-state responder for the main scenarios, a 0-wait one for latency.
module tb_dmem_ll_responder;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ce2 = 1'b0, ce0 = 1'b0, we = 1'b0, ll = 1'b0, sc = 1'b0, flush = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata2, rdata0;
  logic        ready2, err2, llbit2, ready0, err0, llbit0;

  dmem_ll_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut2 (
    .clk(clk), .rst(rst), .ce(ce2), .we(we), .ll(ll), .sc(sc), .addr(addr), .wdata(wdata),
    .flush(flush), .rdata(rdata2), .ready(ready2), .err(err2), .llbit(llbit2));

  dmem_ll_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce0), .we(we), .ll(ll), .sc(sc), .addr(addr), .wdata(wdata),
    .flush(flush), .rdata(rdata0), .ready(ready0), .err(err0), .llbit(llbit0));

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitors: pop the oldest expectation on every ready pulse
  always @(negedge clk) begin
    exp_t e;
    if (ready2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_ready2 @cycle %0d", cyc);
      end else begin
        e = q2.pop_front();
        check32("latency2", cyc, e.cyc);
        check32("err2", {31'd0, err2}, {31'd0, e.err});
        if (e.chk) check32("rdata2", rdata2, e.rdata);
      end
    end
    if (ready0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_ready0 @cycle %0d", cyc);
      end else begin
        e = q0.pop_front();
        check32("latency0", cyc, e.cyc);
        check32("err0", {31'd0, err0}, {31'd0, e.err});
        if (e.chk) check32("rdata0", rdata0, e.rdata);
      end
    end
  end

  // Issue one request at a negedge with the target idle; junk inputs while busy must be ignored.
  task automatic req(input int wc, input bit w, input bit l, input bit s,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input bit chk, input bit ee,
                     input int fl_at, input int rst_at);
    exp_t e;
    we = w; ll = l; sc = s; addr = a; wdata = d;
    if (wc == W) ce2 = 1'b1; else ce0 = 1'b1;
    if (rst_at == 0) begin
      e.rdata = er; e.chk = chk; e.err = ee; e.cyc = cyc + wc + 1;
      if (wc == W) q2.push_back(e); else q0.push_back(e);
    end
    for (int i = 1; i <= wc + 2; i++) begin
      @(negedge clk);
      flush = (i == fl_at);
      rst   = (i == rst_at);
      if (i <= wc + 1 && rst_at == 0) begin
        we = 1'b1; ll = 1'b0; sc = 1'b0; addr = 32'h10; wdata = 32'h0BADF00D;
      end else begin
        ce2 = 1'b0; ce0 = 1'b0;
      end
    end
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    req(W, 1'b1, 1'b0, 1'b0, a, d, 32'd0, 1'b0, 1'b0, 0, 0);
  endtask
  task automatic ld(input logic [31:0] a, input logic [31:0] er);
    req(W, 1'b0, 1'b0, 1'b0, a, 32'd0, er, 1'b1, 1'b0, 0, 0);
  endtask
  task automatic lld(input logic [31:0] a, input logic [31:0] er, input int fl_at);
    req(W, 1'b0, 1'b1, 1'b0, a, 32'd0, er, 1'b1, 1'b0, fl_at, 0);
  endtask
  task automatic scd(input logic [31:0] a, input logic [31:0] d, input bit ok, input int fl_at);
    req(W, 1'b1, 1'b0, 1'b1, a, d, {31'd0, ok}, 1'b1, 1'b0, fl_at, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check32("rst_ready", {31'd0, ready2}, 32'd0);
    check32("rst_err",   {31'd0, err2},   32'd0);
    check32("rst_rdata", rdata2,          32'd0);
    check32("rst_llbit", {31'd0, llbit2}, 32'd0);
    check32("rst_rdata0", rdata0,         32'd0);

    st(32'h10, 32'hDEADBEEF);
    ld(32'h10, 32'hDEADBEEF);

    // LL then SC succeeds
    st(32'h20, 32'hAAAA0000);
    lld(32'h20, 32'hAAAA0000, 0);
    check32("ll_sets", {31'd0, llbit2}, 32'd1);
    scd(32'h20, 32'h1234, 1'b1, 0);
    check32("sc_clears", {31'd0, llbit2}, 32'd0);
    ld(32'h20, 32'h1234);

    // Store to the linked word breaks the reservation
    lld(32'h20, 32'h1234, 0);
    st(32'h20, 32'h5555);
    check32("sw_breaks", {31'd0, llbit2}, 32'd0);
    scd(32'h20, 32'h9999, 1'b0, 0);
    ld(32'h20, 32'h5555);

    // Store to another word keeps it
    lld(32'h20, 32'h5555, 0);
    st(32'h24, 32'h7777);
    check32("sw_other_keeps", {31'd0, llbit2}, 32'd1);
    scd(32'h20, 32'h8888, 1'b1, 0);
    ld(32'h20, 32'h8888);
    ld(32'h24, 32'h7777);

    // Flush between LL and SC
    lld(32'h20, 32'h8888, 0);
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    check32("flush_clears", {31'd0, llbit2}, 32'd0);
    scd(32'h20, 32'h0BAD, 1'b0, 0);
    ld(32'h20, 32'h8888);

    // Flush on the commit edge of an LL, then of an SC
    lld(32'h20, 32'h8888, W);
    check32("flush_beats_ll", {31'd0, llbit2}, 32'd0);
    lld(32'h20, 32'h8888, 0);
    scd(32'h20, 32'h0CCC, 1'b0, W);
    ld(32'h20, 32'h8888);

    // Illegal requests
    req(W, 1'b1, 1'b0, 1'b0, 32'h13, 32'hFFFF, 32'd0, 1'b1, 1'b1, 0, 0);
    ld(32'h10, 32'hDEADBEEF);
    req(W, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 32'd0, 1'b1, 1'b1, 0, 0);
    ld(32'h10 | (32'd1 << 12), 32'hDEADBEEF);

    // Reset in the middle of a store
    st(32'h40, 32'h11111111);
    lld(32'h40, 32'h11111111, 0);
    check32("ll_before_rst", {31'd0, llbit2}, 32'd1);
    req(W, 1'b1, 1'b0, 1'b0, 32'h40, 32'h22222222, 32'd0, 1'b0, 1'b0, 0, 1);
    check32("rst_mid_llbit", {31'd0, llbit2}, 32'd0);
    check32("rst_mid_rdata", rdata2, 32'd0);
    ld(32'h40, 32'h11111111);

    // Zero-wait instance
    req(0, 1'b1, 1'b0, 1'b0, 32'h8, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0, 0, 0);
    req(0, 1'b0, 1'b0, 1'b0, 32'h8, 32'd0, 32'hCAFEF00D, 1'b1, 1'b0, 0, 0);
    req(0, 1'b0, 1'b1, 1'b0, 32'h8, 32'd0, 32'hCAFEF00D, 1'b1, 1'b0, 0, 0);
    check32("ll_sets0", {31'd0, llbit0}, 32'd1);

    repeat (5) @(negedge clk);
    check32("q2_drained", q2.size(), 32'd0);
    check32("q0_drained", q0.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
